// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and their FIFOs.
package uart_pkg;
  localparam int UART_WIDTH      = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUD_RATE       = 9600;
  localparam int BAUD_DIV        = 5208;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO and FIFO-to-consumer signal bundle.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_WIDTH,
  parameter int DEPTH = UART_FIFO_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             rx_done;
  logic [WIDTH-1:0] rx_data;
  logic             rd_en;
  logic             clr_ovf;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;

  modport master (
    output rx_done, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );
  modport slave (
    input  rx_done, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read (latency 1); full/empty derived from count.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             rd_ok, wr_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign wr_ok = wr_en & (~full | rd_ok);

  always_ff @(posedge Clk) begin
    if (!Reset && wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: one FIFO entry per rising edge of rx_done, sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int WIDTH = UART_WIDTH,
  parameter  int DEPTH = UART_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           Clk,
  input  logic           Reset,
  uart_rx_fifo_if.slave  bus
);
  logic done_q, wr_req, rd_ok, ovf_q;
  logic fifo_empty, fifo_full;

  // Clearing done_q on reset makes a still-high rx_done count as a fresh byte.
  always_ff @(posedge Clk) begin
    if (Reset) done_q <= 1'b0;
    else       done_q <= bus.rx_done;
  end

  assign wr_req = bus.rx_done & ~done_q;
  assign rd_ok  = bus.rd_en & ~fifo_empty;

  always_ff @(posedge Clk) begin
    if (Reset)                           ovf_q <= 1'b0;
    else if (wr_req & fifo_full & ~rd_ok) ovf_q <= 1'b1;
    else if (bus.clr_ovf)                 ovf_q <= 1'b0;
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (wr_req),
    .wr_data  (bus.rx_data),
    .rd_en    (bus.rd_en),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (bus.count)
  );

  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.overflow = ovf_q;
endmodule
